// File: rtl/delay_scheduler_pkg.sv
// Shared definitions for the delay-RAM scheduler: FSM state type, frame
// length and the default RAM geometry also used by the RAM wrapper and the
// effects logic.
package delay_scheduler_pkg;

  // System clock cycles per 48 kHz sample period at 40 MHz.
  localparam int FRAME_CYCLES = 833;

  // Default delay-RAM geometry.
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 11;
  localparam int DEF_NTAPS  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/delay_scheduler_tap_addr.sv
// Tap address generator: wr_ptr - max(delay, 1), wrapping modulo 2^ADDR_W.
// A delay of 0 would read the slot about to be written, so it is clamped
// to 1 (the previous frame's sample).
module delay_scheduler_tap_addr
  import delay_scheduler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] wr_ptr_i,
  input  logic [ADDR_W-1:0] delay_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] eff_delay;

  // Clamp the delay, then subtract; the fixed width provides the wrap.
  always_comb begin
    eff_delay = (delay_i == '0) ? ADDR_W'(1) : delay_i;
    addr_o    = wr_ptr_i - eff_delay;
  end

endmodule

// File: rtl/delay_scheduler.sv
// Delay-RAM scheduler. Each accepted frame pulse runs a fixed schedule on
// the single-port RAM: one read slot per tap, then the write of the current
// sample, then a one-cycle tapValid pulse.
//
// Pulse semantics: frame is a one-cycle request, accepted only in IDLE (a
// pulse in any other state is dropped and sets the sticky overrun flag).
// tapValid is a one-cycle pulse with no back-pressure; tapData holds its
// value until the next sequence overwrites it.
module delay_scheduler
  import delay_scheduler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NTAPS  = DEF_NTAPS
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    frame,
  input  logic                    wrEn,
  input  logic [DATA_W-1:0]       wrData,
  input  logic [NTAPS-1:0]        tapEn,
  input  logic [NTAPS*ADDR_W-1:0] tapDelay,
  output logic [ADDR_W-1:0]       memAddr,
  output logic                    memWE,
  output logic [DATA_W-1:0]       memWData,
  input  logic [DATA_W-1:0]       memRData,
  output logic [NTAPS*DATA_W-1:0] tapData,
  output logic                    tapValid,
  output logic                    busy,
  output logic                    overrun,
  output logic [1:0]              dbg_state_o,
  output logic [ADDR_W-1:0]       dbg_wr_ptr_o
);

  localparam int IDX_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]  wr_ptr_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic               wr_en_q;
  logic [NTAPS-1:0]   tap_en_q;
  logic [ADDR_W-1:0]  delay_q [NTAPS];
  logic [DATA_W-1:0]  tap_data_q [NTAPS];
  logic [DATA_W-1:0]  wdata_hold_q;
  logic               overrun_q;

  logic               accept;
  logic [ADDR_W-1:0]  sel_delay;
  logic [ADDR_W-1:0]  rd_addr;
  logic               cap_en;
  logic [IDX_W-1:0]   cap_idx;

  assign accept    = frame && (state_q == ST_IDLE);
  assign sel_delay = delay_q[idx_q];

  delay_scheduler_tap_addr #(.ADDR_W(ADDR_W)) u_tap_addr (
    .wr_ptr_i (wr_ptr_q),
    .delay_i  (sel_delay),
    .addr_o   (rd_addr)
  );

  // FSM state and tap index register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state and RAM/status outputs, all decoded from the current state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    memAddr  = wr_ptr_q;
    memWE    = 1'b0;
    memWData = wdata_hold_q;
    tapValid = 1'b0;
    busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (frame) begin
          state_d = ST_READ;
          idx_d   = '0;
        end
      end
      ST_READ: begin
        memAddr = rd_addr;
        if (idx_q == LAST_IDX) state_d = ST_WRITE;
        else                   idx_d   = idx_q + 1'b1;
      end
      ST_WRITE: begin
        memWE    = wr_en_q;
        memWData = wr_data_q;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        tapValid = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame-time snapshot of the write sample, enables and delays.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      tap_en_q  <= '0;
      for (int i = 0; i < NTAPS; i++) delay_q[i] <= '0;
    end else if (accept) begin
      wr_data_q <= wrData;
      wr_en_q   <= wrEn;
      tap_en_q  <= tapEn;
      for (int i = 0; i < NTAPS; i++) delay_q[i] <= tapDelay[i*ADDR_W +: ADDR_W];
    end
  end

  // Write pointer advances after every WRITE slot, frozen buffer or not;
  // the write data output keeps the last value driven.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q     <= '0;
      wdata_hold_q <= '0;
    end else if (state_q == ST_WRITE) begin
      wr_ptr_q     <= wr_ptr_q + 1'b1;
      wdata_hold_q <= wr_data_q;
    end
  end

  // Sticky overrun: any frame pulse that arrives outside IDLE.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                          overrun_q <= 1'b0;
    else if (frame && state_q != ST_IDLE) overrun_q <= 1'b1;
  end

  // Read data lags its address by one cycle, so tap i-1 is captured while
  // tap i is addressed, and the last tap during WRITE.
  assign cap_en  = ((state_q == ST_READ) && (idx_q != '0)) || (state_q == ST_WRITE);
  assign cap_idx = (state_q == ST_WRITE) ? LAST_IDX : idx_q - 1'b1;

  // Tap capture registers; disabled taps are zeroed in their slot.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NTAPS; i++) tap_data_q[i] <= '0;
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        if (cap_en && (cap_idx == IDX_W'(i))) begin
          tap_data_q[i] <= tap_en_q[i] ? memRData : '0;
        end
      end
    end
  end

  // Flatten tap registers onto the output bus, tap 0 in the low bits.
  always_comb begin
    tapData = '0;
    for (int i = 0; i < NTAPS; i++) tapData[i*DATA_W +: DATA_W] = tap_data_q[i];
  end

  assign overrun      = overrun_q;
  assign dbg_state_o  = state_q;
  assign dbg_wr_ptr_o = wr_ptr_q;

endmodule

// File: tb/tb_delay_scheduler.sv
// Self-checking bench for delay_scheduler with a behavioural RAM and a
// reference model of the circular buffer feeding an expected-tap queue.
module tb_delay_scheduler;
  import delay_scheduler_pkg::*;

  localparam int AW = 13;
  localparam int DW = 11;
  localparam int NT = 3;

  logic             clk;
  logic             nreset;
  logic             frame;
  logic             wrEn;
  logic [DW-1:0]    wrData;
  logic [NT-1:0]    tapEn;
  logic [NT*AW-1:0] tapDelay;
  logic [AW-1:0]    memAddr;
  logic             memWE;
  logic [DW-1:0]    memWData;
  logic [DW-1:0]    memRData;
  logic [NT*DW-1:0] tapData;
  logic             tapValid;
  logic             busy;
  logic             overrun;
  logic [1:0]       dbg_state;
  logic [AW-1:0]    dbg_wr_ptr;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ram     [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  logic [AW-1:0] ref_ptr;

  delay_scheduler #(.ADDR_W(AW), .DATA_W(DW), .NTAPS(NT)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .frame        (frame),
    .wrEn         (wrEn),
    .wrData       (wrData),
    .tapEn        (tapEn),
    .tapDelay     (tapDelay),
    .memAddr      (memAddr),
    .memWE        (memWE),
    .memWData     (memWData),
    .memRData     (memRData),
    .tapData      (tapData),
    .tapValid     (tapValid),
    .busy         (busy),
    .overrun      (overrun),
    .dbg_state_o  (dbg_state),
    .dbg_wr_ptr_o (dbg_wr_ptr)
  );

  // Clock
  initial clk = 1'b0;
  always #12 clk = ~clk;

  // Synchronous single-port RAM, read data one cycle after the address.
  always @(posedge clk) begin
    if (memWE) ram[memAddr] <= memWData;
    memRData <= ram[memAddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] tap_of(input int t);
    return tapData[t*DW +: DW];
  endfunction

  // Drive one frame, push expected taps, follow the schedule and score it.
  // extra_at > 0 re-pulses frame in that cycle of the sequence.
  task automatic do_frame(input logic [DW-1:0] data, input logic we, input logic [NT-1:0] ten,
                          input logic [AW-1:0] d0, input logic [AW-1:0] d1, input logic [AW-1:0] d2,
                          input int extra_at, output logic [AW-1:0] first_addr);
    logic [AW-1:0] dl [NT];
    logic [AW-1:0] dd;
    logic [AW-1:0] a;
    int lat;
    int we_cnt;
    bit seen;
    dl[0] = d0; dl[1] = d1; dl[2] = d2;
    for (int t = 0; t < NT; t++) begin
      dd = (dl[t] == '0) ? AW'(1) : dl[t];
      a  = ref_ptr - dd;
      exp_q.push_back(ten[t] ? ref_mem[a] : '0);
    end
    @(negedge clk);
    frame = 1'b1; wrData = data; wrEn = we; tapEn = ten; tapDelay = {d2, d1, d0};
    @(negedge clk);
    frame = 1'b0;
    lat = 1; we_cnt = 0; seen = 1'b0;
    first_addr = memAddr;
    check("busy_start", busy, 1);
    while (!seen && lat <= 20) begin
      frame = (lat == extra_at);
      if (memWE) begin
        we_cnt++;
        check("wr_addr", memAddr, ref_ptr);
        check("wr_data", memWData, data);
      end
      if (tapValid) seen = 1'b1;
      else begin
        @(negedge clk);
        frame = 1'b0;
        lat++;
      end
    end
    check("latency", lat, NT + 2);
    check("we_count", we_cnt, we ? 1 : 0);
    for (int t = 0; t < NT; t++) begin
      if (seen) check($sformatf("tap%0d", t), tap_of(t), exp_q.pop_front());
      else begin
        check($sformatf("tap%0d_timeout", t), 0, 1);
        void'(exp_q.pop_front());
      end
    end
    if (we) ref_mem[ref_ptr] = data;
    ref_ptr = ref_ptr + 1'b1;
    check("wr_ptr", dbg_wr_ptr, ref_ptr);
    if (frame) begin
      @(negedge clk);
      frame = 1'b0;
    end
  endtask

  task automatic idle_watch();
    int n;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (tapValid) n++;
    end
    check("no_extra_valid", n, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_memWE"}, memWE, 0);
    check({pfx, "_memAddr"}, memAddr, 0);
    check({pfx, "_memWData"}, memWData, 0);
    check({pfx, "_tapData"}, tapData, 0);
    check({pfx, "_tapValid"}, tapValid, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_overrun"}, overrun, 0);
    check({pfx, "_state"}, dbg_state, 0);
    check({pfx, "_wr_ptr"}, dbg_wr_ptr, 0);
  endtask

  initial begin
    logic [AW-1:0] fa;
    logic [AW-1:0] p;
    logic [DW-1:0] d;

    // Reset
    nreset = 1'b0; frame = 1'b0; wrEn = 1'b0; wrData = '0; tapEn = '0; tapDelay = '0;
    for (int i = 0; i < 2**AW; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    ref_ptr = '0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    nreset = 1'b1;
    @(negedge clk);

    // Basic delays {1,2,5} over samples 1..10
    for (int k = 1; k <= 10; k++) do_frame(DW'(k), 1'b1, 3'b111, 13'd1, 13'd2, 13'd5, 0, fa);
    check("basic_tap0", tap_of(0), 9);
    check("basic_tap1", tap_of(1), 8);
    check("basic_tap2", tap_of(2), 5);

    // Delay 0 behaves as delay 1
    p = ref_ptr;
    do_frame(11'h155, 1'b1, 3'b111, 13'd0, 13'd1, 13'd3, 0, fa);
    check("d0_addr", fa, p - 1'b1);
    check("d0_tap0", tap_of(0), 10);
    check("d0_tap1", tap_of(1), 10);

    // Enables: only tap 1
    do_frame(11'h2a, 1'b1, 3'b010, 13'd3, 13'd4, 13'd5, 0, fa);
    check("en_tap0_zero", tap_of(0), 0);
    check("en_tap2_zero", tap_of(2), 0);

    // Frozen buffer: no write, pointer still moves
    do_frame(11'h7ff, 1'b0, 3'b111, 13'd1, 13'd2, 13'd3, 0, fa);
    do_frame(11'h0f0, 1'b1, 3'b111, 13'd1, 13'd2, 13'd3, 0, fa);
    check("freeze_tap0", tap_of(0), 0);

    // Wrap-around: run the pointer up to 8190
    while (ref_ptr != 13'd8190) begin
      do_frame(DW'($urandom_range(0, 2047)), 1'b1, 3'b111,
               AW'($urandom_range(0, 40)), AW'($urandom_range(0, 40)),
               AW'($urandom_range(0, 40)), 0, fa);
    end
    do_frame(11'h123, 1'b1, 3'b111, 13'd3, 13'd1, 13'd2, 0, fa);
    check("wrap_addr_d3", fa, 8187);
    do_frame(11'h456, 1'b1, 3'b111, 13'd1, 13'd2, 13'd3, 0, fa);
    check("wrap_ptr_zero", dbg_wr_ptr, 0);
    do_frame(11'h321, 1'b1, 3'b111, 13'd1, 13'd2, 13'd3, 0, fa);
    check("wrap_addr_d1", fa, 8191);
    check("wrap_tap0", tap_of(0), 11'h456);

    // Reset during the WRITE slot aborts the write
    p = ref_ptr;
    @(negedge clk);
    frame = 1'b1; wrData = 11'h5a5; wrEn = 1'b1; tapEn = 3'b111; tapDelay = {13'd1, 13'd1, 13'd1};
    @(negedge clk);
    frame = 1'b0;
    repeat (NT) @(negedge clk);
    check("pre_rst_memWE", memWE, 1);
    #2 nreset = 1'b0;
    #1 check_reset_values("midrst");
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    check("midrst_no_write", ram[p], ref_mem[p]);
    check("midrst_ptr", dbg_wr_ptr, 0);
    ref_ptr = '0;

    // Frame in the DONE cycle is an overrun, not a new sequence
    do_frame(11'h011, 1'b1, 3'b111, 13'd1, 13'd2, 13'd3, NT + 2, fa);
    check("ovr_done", overrun, 1);
    idle_watch();

    // Frame three cycles into a sequence
    do_frame(11'h022, 1'b1, 3'b111, 13'd1, 13'd2, 13'd3, 3, fa);
    check("ovr_mid", overrun, 1);
    idle_watch();

    // Next legal frame still runs; overrun remains set
    do_frame(11'h033, 1'b1, 3'b111, 13'd1, 13'd2, 13'd3, 0, fa);
    check("ovr_legal_tap0", tap_of(0), 11'h022);
    check("ovr_sticky", overrun, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
